// File: rtl/rv32i_pkg.sv
// Shared RV32I load/store encodings, bus_master FSM states and the latched request payload.
package rv32i_pkg;

  localparam int unsigned      XLEN              = 32;
  localparam logic [XLEN-1:0]  ADDR_BASE_DEFAULT = 32'h8000_0000;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [2:0] {
    IDLE, RD, MERGE, WR_DRV, WR_HOLD, WR_TURN, RESP
  } state_e;

  typedef struct packed {
    logic            we;
    logic [2:0]      funct3;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
  } lsu_req_t;

  // Encoding and alignment legality; the address window is checked by the user.
  function automatic logic access_illegal(input logic we, input logic [2:0] funct3,
                                          input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b1;
    case (funct3)
      F3_B:    bad = 1'b0;
      F3_H:    bad = addr_lo[0];
      F3_W:    bad = (addr_lo != 2'b00);
      F3_BU:   bad = we;
      F3_HU:   bad = we | addr_lo[0];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/bus_master_if.sv
// Load/store request and response handshake; the requester uses master, bus_master uses slave.
interface bus_master_if;
  import rv32i_pkg::*;

  logic            i_req_valid;
  logic            o_req_ready;
  logic            i_req_we;
  logic [2:0]      i_req_funct3;
  logic [XLEN-1:0] i_req_addr;
  logic [XLEN-1:0] i_req_wdata;
  logic            o_rsp_valid;
  logic [XLEN-1:0] o_rsp_rdata;
  logic            o_rsp_err;

  modport master (
    output i_req_valid, i_req_we, i_req_funct3, i_req_addr, i_req_wdata,
    input  o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err
  );

  modport slave (
    input  i_req_valid, i_req_we, i_req_funct3, i_req_addr, i_req_wdata,
    output o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err
  );
endinterface

// File: rtl/lsu_lane.sv
// Byte/half lane extraction with sign/zero extension, and sub-word merge into a read word.
module lsu_lane
  import rv32i_pkg::*;
(
  input  logic [XLEN-1:0] word,
  input  logic [XLEN-1:0] wdata,
  input  logic [1:0]      addr_lo,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] load_data_c,
  output logic [XLEN-1:0] merge_data_c
);

  logic [4:0]      shamt;
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] lane_mask;

  assign shamt   = {addr_lo, 3'b000};
  assign shifted = word >> shamt;

  always_comb begin
    load_data_c = word;
    case (funct3)
      F3_B:    load_data_c = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      F3_BU:   load_data_c = {{(XLEN-8){1'b0}}, shifted[7:0]};
      F3_H:    load_data_c = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      F3_HU:   load_data_c = {{(XLEN-16){1'b0}}, shifted[15:0]};
      default: load_data_c = word;
    endcase
  end

  always_comb begin
    lane_mask = '1;
    case (funct3)
      F3_B:    lane_mask = XLEN'(32'h0000_00FF) << shamt;
      F3_H:    lane_mask = XLEN'(32'h0000_FFFF) << shamt;
      default: lane_mask = '1;
    endcase
    merge_data_c = (word & ~lane_mask) | ((wdata << shamt) & lane_mask);
  end

endmodule

// File: rtl/bus_master.sv
// RV32I load/store master onto a shared tristate memory bus; o_memread low is the write window.
module bus_master
  import rv32i_pkg::*;
#(
  parameter logic [XLEN-1:0] ADDR_BASE = ADDR_BASE_DEFAULT,
  parameter int unsigned     MEM_BYTES = 1024
) (
  input  logic            i_clk,
  input  logic            i_nreset,
  bus_master_if.slave     bus,
  output logic [XLEN-1:0] o_memaddr,
  output logic            o_memread,
  inout  wire  [XLEN-1:0] b_membus
);

  localparam int unsigned   AW1    = XLEN + 1;
  localparam logic [XLEN:0] WIN_LO = AW1'(ADDR_BASE);
  localparam logic [XLEN:0] WIN_HI = AW1'(ADDR_BASE) + AW1'(MEM_BYTES);

  state_e          state, state_d;
  lsu_req_t        req_c, req_q;
  logic            accept_c, req_err_c, in_window_c;
  logic [XLEN-1:0] rd_word, wr_word, lane_word_c, load_data_c, merge_data_c;
  logic            bus_oe, req_ready, rsp_valid, rsp_err;
  logic [XLEN-1:0] rsp_rdata;
  logic            memread_d, bus_oe_d, ready_d, rsp_valid_d;

  assign req_c = '{we: bus.i_req_we, funct3: bus.i_req_funct3,
                   addr: bus.i_req_addr, wdata: bus.i_req_wdata};

  assign in_window_c = (AW1'(req_c.addr) >= WIN_LO) && (AW1'(req_c.addr) < WIN_HI);
  assign req_err_c   = access_illegal(req_c.we, req_c.funct3, req_c.addr[1:0]) || !in_window_c;
  assign accept_c    = bus.i_req_valid && req_ready;

  always_ff @(posedge i_clk or negedge i_nreset) begin
    if (!i_nreset) state <= IDLE;
    else           state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE: begin
        if (accept_c) begin
          if (req_err_c)                               state_d = RESP;
          else if (req_c.we && req_c.funct3 == F3_W)   state_d = WR_DRV;
          else                                         state_d = RD;
        end
      end
      RD:      state_d = req_q.we ? MERGE : RESP;
      MERGE:   state_d = WR_DRV;
      WR_DRV:  state_d = WR_HOLD;
      WR_HOLD: state_d = WR_TURN;
      WR_TURN: state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output values for the upcoming state, registered below so they line up with it.
  always_comb begin
    memread_d   = 1'b1;
    bus_oe_d    = 1'b0;
    ready_d     = 1'b0;
    rsp_valid_d = 1'b0;
    case (state_d)
      IDLE:            ready_d = 1'b1;
      WR_DRV, WR_HOLD: begin
        memread_d = 1'b0;
        bus_oe_d  = 1'b1;
      end
      WR_TURN:         memread_d = 1'b0;
      RESP:            rsp_valid_d = 1'b1;
      default:         ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_nreset) begin
    if (!i_nreset) begin
      o_memread <= 1'b1;
      bus_oe    <= 1'b0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
    end else begin
      o_memread <= memread_d;
      bus_oe    <= bus_oe_d;
      req_ready <= ready_d;
      rsp_valid <= rsp_valid_d;
    end
  end

  // Request latch only on legal accepts, so the address bus holds across error responses.
  always_ff @(posedge i_clk or negedge i_nreset) begin
    if (!i_nreset) begin
      req_q     <= '0;
      rd_word   <= '0;
      wr_word   <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if (accept_c && !req_err_c) begin
        req_q   <= req_c;
        wr_word <= req_c.wdata;
      end
      if (state == RD)    rd_word <= b_membus;
      if (state == MERGE) wr_word <= merge_data_c;
      if (state_d == RESP) begin
        rsp_err   <= (state == IDLE);
        rsp_rdata <= (state == RD) ? load_data_c : '0;
      end
    end
  end

  assign lane_word_c = (state == MERGE) ? rd_word : b_membus;

  lsu_lane u_lane (
    .word         (lane_word_c),
    .wdata        (req_q.wdata),
    .addr_lo      (req_q.addr[1:0]),
    .funct3       (req_q.funct3),
    .load_data_c  (load_data_c),
    .merge_data_c (merge_data_c)
  );

  assign o_memaddr       = {req_q.addr[XLEN-1:2], 2'b00};
  assign b_membus        = bus_oe ? wr_word : 'z;
  assign bus.o_req_ready = req_ready;
  assign bus.o_rsp_valid = rsp_valid;
  assign bus.o_rsp_rdata = rsp_rdata;
  assign bus.o_rsp_err   = rsp_err;

endmodule

// File: tb/tb_bus_master.sv
// Self-checking bench for bus_master: tristate memory model plus an expected-response scoreboard.
module tb_bus_master;
  import rv32i_pkg::*;

  localparam logic [31:0] BASE      = 32'h8000_0000;
  localparam int unsigned MEM_BYTES = 1024;
  localparam int unsigned WORDS     = MEM_BYTES / 4;
  localparam int          BOUND     = 20;

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          n0;
  } exp_t;

  logic        i_clk = 1'b0;
  logic        i_nreset;
  logic [31:0] o_memaddr;
  logic        o_memread;
  wire  [31:0] b_membus;

  bus_master_if bus ();

  bus_master #(.ADDR_BASE(BASE), .MEM_BYTES(MEM_BYTES)) dut (
    .i_clk     (i_clk),
    .i_nreset  (i_nreset),
    .bus       (bus),
    .o_memaddr (o_memaddr),
    .o_memread (o_memread),
    .b_membus  (b_membus)
  );

  always #5 i_clk = ~i_clk;

  // Memory model: drives the bus while o_memread is high, commits a write when the strobe ends.
  logic [31:0] mem [WORDS];
  logic [31:0] mem_rd, mem_off;
  logic        mem_hit;
  logic        wr_cap = 1'b0;
  logic [31:0] wr_data, wr_addr;
  logic        poke_en = 1'b0;
  int          poke_idx;
  logic [31:0] poke_val;
  int          falls = 0;
  int          conflicts = 0;
  int          ncyc = 0;
  int          tests = 0;
  int          fails = 0;
  exp_t        sb[$];

  always_comb begin
    mem_off = o_memaddr - BASE;
    mem_hit = (o_memaddr >= BASE) && (o_memaddr < BASE + MEM_BYTES);
    mem_rd  = mem_hit ? mem[mem_off[9:2]] : 32'h0;
  end

  assign b_membus = o_memread ? mem_rd : 'z;

  always @(negedge i_clk) begin
    if (poke_en) mem[poke_idx] = poke_val;
    if (!o_memread && !wr_cap) begin
      wr_cap  = 1'b1;
      wr_data = b_membus;
      wr_addr = o_memaddr;
    end
    if (o_memread && wr_cap) begin
      if (i_nreset) mem[wr_addr[9:2]] = wr_data;
      wr_cap = 1'b0;
    end
    if (i_nreset && o_memread && b_membus !== mem_rd) conflicts = conflicts + 1;
  end

  always @(negedge o_memread) falls = falls + 1;
  always @(posedge i_clk) ncyc <= ncyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests = tests + 1;
    if (got !== exp) begin
      fails = fails + 1;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic poke(input int idx, input logic [31:0] val);
    poke_idx = idx;
    poke_val = val;
    poke_en  = 1'b1;
    @(negedge i_clk);
    #1 poke_en = 1'b0;
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    @(negedge i_clk);
    while (bus.o_req_ready !== 1'b1 && n < BOUND) begin
      @(negedge i_clk);
      n++;
    end
    if (n >= BOUND) check_eq({name, "_ready_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic issue(input string name, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] er, input logic ee, input int el);
    exp_t e;
    int   n, f0;
    logic got;
    wait_ready(name);
    bus.i_req_valid  = 1'b1;
    bus.i_req_we     = we;
    bus.i_req_funct3 = f3;
    bus.i_req_addr   = addr;
    bus.i_req_wdata  = wd;
    e.name  = name;
    e.rdata = er;
    e.err   = ee;
    e.lat   = el;
    e.n0    = ncyc;
    sb.push_back(e);
    f0 = falls;
    @(posedge i_clk);
    #1;
    bus.i_req_valid  = 1'b0;
    bus.i_req_we     = ~we;
    bus.i_req_funct3 = 3'($urandom);
    bus.i_req_addr   = $urandom;
    bus.i_req_wdata  = $urandom;
    n   = 0;
    got = 1'b0;
    while (!got && n < BOUND) begin
      @(negedge i_clk);
      n++;
      got = bus.o_rsp_valid;
    end
    if (!got) begin
      check_eq({name, "_rsp_timeout"}, 32'd0, 32'd1);
      void'(sb.pop_front());
    end else begin
      e = sb.pop_front();
      check_eq({e.name, "_rdata"}, bus.o_rsp_rdata, e.rdata);
      check_eq({e.name, "_err"}, 32'(bus.o_rsp_err), 32'(e.err));
      check_eq({e.name, "_latency"}, 32'(ncyc - e.n0), 32'(e.lat));
      @(negedge i_clk);
      check_eq({e.name, "_rsp_pulse"}, 32'(bus.o_rsp_valid), 32'd0);
      check_eq({e.name, "_ready_back"}, 32'(bus.o_req_ready), 32'd1);
      check_eq({e.name, "_rdata_held"}, bus.o_rsp_rdata, e.rdata);
    end
    check_eq({name, "_memread_falls"}, 32'(falls - f0), 32'(we && !ee));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    i_nreset         = 1'b0;
    bus.i_req_valid  = 1'b0;
    bus.i_req_we     = 1'b0;
    bus.i_req_funct3 = 3'd0;
    bus.i_req_addr   = 32'h0;
    bus.i_req_wdata  = 32'h0;
    repeat (3) @(negedge i_clk);
    check_eq("rst_memread", 32'(o_memread), 32'd1);
    check_eq("rst_memaddr", o_memaddr, 32'h0);
    check_eq("rst_rsp_valid", 32'(bus.o_rsp_valid), 32'd0);
    check_eq("rst_rdata", bus.o_rsp_rdata, 32'h0);
    check_eq("rst_err", 32'(bus.o_rsp_err), 32'd0);
    check_eq("rst_ready", 32'(bus.o_req_ready), 32'd0);
    check_eq("rst_bus", b_membus, mem_rd);
    i_nreset = 1'b1;
    @(negedge i_clk);
    check_eq("ready_after_rst", 32'(bus.o_req_ready), 32'd1);

    // Loads
    poke(64, 32'hDEAD_BEEF);
    issue("lw_100", 1'b0, F3_W, 32'h8000_0100, 32'h0, 32'hDEAD_BEEF, 1'b0, 2);
    poke(64, 32'h80FF_7F01);
    issue("lb_103",  1'b0, F3_B,  32'h8000_0103, 32'h0, 32'hFFFF_FF80, 1'b0, 2);
    issue("lbu_103", 1'b0, F3_BU, 32'h8000_0103, 32'h0, 32'h0000_0080, 1'b0, 2);
    issue("lb_101",  1'b0, F3_B,  32'h8000_0101, 32'h0, 32'h0000_007F, 1'b0, 2);
    issue("lh_102",  1'b0, F3_H,  32'h8000_0102, 32'h0, 32'hFFFF_80FF, 1'b0, 2);
    issue("lhu_100", 1'b0, F3_HU, 32'h8000_0100, 32'h0, 32'h0000_7F01, 1'b0, 2);

    // Sub-word stores via read-modify-write
    poke(16, 32'h1122_3344);
    issue("sh_042", 1'b1, F3_H, 32'h8000_0042, 32'h0000_ABCD, 32'h0, 1'b0, 6);
    check_eq("mem_after_sh", mem[16], 32'hABCD_3344);
    issue("sb_041", 1'b1, F3_B, 32'h8000_0041, 32'hFFFF_FF5A, 32'h0, 1'b0, 6);
    check_eq("mem_after_sb", mem[16], 32'hABCD_5A44);
    issue("lhu_042", 1'b0, F3_HU, 32'h8000_0042, 32'h0, 32'h0000_ABCD, 1'b0, 2);

    // Word store and read-back
    issue("sw_004", 1'b1, F3_W, 32'h8000_0004, 32'h1234_5678, 32'h0, 1'b0, 4);
    check_eq("mem_after_sw", mem[1], 32'h1234_5678);
    issue("lw_004", 1'b0, F3_W, 32'h8000_0004, 32'h0, 32'h1234_5678, 1'b0, 2);

    // Error requests: no bus cycle, one-cycle response
    issue("err_lw_mis",  1'b0, F3_W,  32'h8000_0002, 32'h0, 32'h0, 1'b1, 1);
    issue("err_sh_mis",  1'b1, F3_H,  32'h8000_0001, 32'hFFFF, 32'h0, 1'b1, 1);
    issue("err_lw_oow",  1'b0, F3_W,  32'h8000_0400, 32'h0, 32'h0, 1'b1, 1);
    issue("err_f3_3",    1'b0, 3'd3,  32'h8000_0000, 32'h0, 32'h0, 1'b1, 1);
    issue("err_st_f3_4", 1'b1, F3_BU, 32'h8000_0000, 32'h0, 32'h0, 1'b1, 1);
    issue("err_below",   1'b0, F3_W,  32'h7FFF_FFFC, 32'h0, 32'h0, 1'b1, 1);
    check_eq("mem_after_err", mem[1], 32'h1234_5678);

    // Reset asserted during WR_HOLD aborts the store
    poke(2, 32'hCAFE_F00D);
    wait_ready("abort_sw");
    bus.i_req_valid  = 1'b1;
    bus.i_req_we     = 1'b1;
    bus.i_req_funct3 = F3_W;
    bus.i_req_addr   = 32'h8000_0008;
    bus.i_req_wdata  = 32'h5555_5555;
    @(posedge i_clk);
    #1 bus.i_req_valid = 1'b0;
    @(negedge i_clk);
    @(negedge i_clk);
    check_eq("abort_in_write", 32'(o_memread), 32'd0);
    #1 i_nreset = 1'b0;
    #1;
    check_eq("abort_memread", 32'(o_memread), 32'd1);
    check_eq("abort_bus", b_membus, mem_rd);
    check_eq("abort_rsp", 32'(bus.o_rsp_valid), 32'd0);
    repeat (2) begin
      @(negedge i_clk);
      check_eq("abort_rsp_rst", 32'(bus.o_rsp_valid), 32'd0);
    end
    i_nreset = 1'b1;
    repeat (4) begin
      @(negedge i_clk);
      check_eq("abort_rsp_post", 32'(bus.o_rsp_valid), 32'd0);
    end
    check_eq("abort_mem", mem[2], 32'hCAFE_F00D);
    issue("lw_008", 1'b0, F3_W, 32'h8000_0008, 32'h0, 32'hCAFE_F00D, 1'b0, 2);

    check_eq("bus_conflicts", 32'(conflicts), 32'd0);
    check_eq("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bus_master.md
BUS_MASTER -- requirements
Module: bus_master

Interface
REQ-001 SHALL have parameter ADDR_BASE, default 32'h80000000, base byte address of the memory window.
REQ-002 SHALL have parameter MEM_BYTES, default 1024, size of the memory window in bytes.
REQ-003 SHALL have ports i_clk (in, 1, clock) and i_nreset (in, 1, reset, asynchronous, active-low).
REQ-004 SHALL have ports i_req_valid (in, 1), o_req_ready (out, 1), i_req_we (in, 1, store), i_req_funct3 (in, 3, RV32I load/store funct3), i_req_addr (in, 32, byte address), i_req_wdata (in, 32, store data, LSB-aligned).
REQ-005 SHALL have ports o_rsp_valid (out, 1), o_rsp_rdata (out, 32, extended load data), o_rsp_err (out, 1, misaligned, illegal or out-of-window).
REQ-006 SHALL have ports o_memaddr (out, 32, byte address), o_memread (out, 1, high = memory drives bus; falling edge = write strobe) and b_membus (inout, 32, shared data bus).

Function
REQ-007 SHALL use the states IDLE, RD, MERGE, WR_DRV, WR_HOLD, WR_TURN and RESP.
REQ-008 SHALL assert o_req_ready only in IDLE; a request is accepted on a rising edge with i_req_valid && o_req_ready.
REQ-009 SHALL latch addr, we, funct3 and wdata on acceptance; later changes to the inputs SHALL have no effect.
REQ-010 SHALL classify as error: funct3 not in {0,1,2,4,5} for loads or {0,1,2} for stores; halfword with addr[0]=1; word with addr[1:0]!=0; addr outside [ADDR_BASE, ADDR_BASE+MEM_BYTES-1].
REQ-011 SHALL go from IDLE to RESP on an error request, issuing no bus cycle, with o_rsp_err=1 and o_rsp_rdata=0.
REQ-012 SHALL drive o_memaddr = {addr[31:2],2'b00} from the cycle after acceptance until RESP, and hold its last value otherwise.
REQ-013 SHALL, for a load, hold RD for one cycle with o_memread=1 and master bus driver off, sample b_membus at the end of RD, then enter RESP.
REQ-014 SHALL return load data in RESP by byte/half lane select on addr[1:0]: lb/lh sign-extend, lbu/lhu zero-extend, lw pass-through.
REQ-015 SHALL, for sw, go IDLE -> WR_DRV -> WR_HOLD -> WR_TURN -> RESP; for sb/sh, go IDLE -> RD -> MERGE -> WR_DRV -> WR_HOLD -> WR_TURN -> RESP.
REQ-016 SHALL, in MERGE, replace only the addressed byte/half lanes of the RD-sampled word with the low bits of wdata.
REQ-017 SHALL drive o_memread=0 and drive the store word onto b_membus in both WR_DRV and WR_HOLD.
REQ-018 SHALL release b_membus in WR_TURN while keeping o_memread=0, and return o_memread to 1 in RESP.
REQ-019 SHALL never drive b_membus while o_memread=1.
REQ-020 SHALL produce exactly one falling edge of o_memread per store and none per load or error.
REQ-021 SHALL pulse o_rsp_valid for exactly one cycle (RESP), with o_rsp_rdata=0 for stores; o_rsp_rdata and o_rsp_err SHALL be held until the next RESP.
REQ-022 SHALL have latencies from the acceptance edge to o_rsp_valid of 2 cycles (lw/lb/lh/lbu/lhu), 4 cycles (sw), 6 cycles (sb/sh) and 1 cycle (error).
REQ-023 SHALL accept a request presented while o_rsp_valid=1 on the following cycle, when the block is back in IDLE.

Reset
REQ-024 SHALL, while i_nreset=0, force state IDLE, o_memread=1, b_membus released, o_memaddr=0, o_rsp_valid=0, o_rsp_rdata=0, o_rsp_err=0 and o_req_ready=0; o_req_ready SHALL rise on the first clock edge after release.
REQ-025 SHALL, on reset asserted mid-store, abort the store: the resulting rise of o_memread causes no write, and no response is produced.

Structure
REQ-026 SHALL take funct3 encodings, the state enumeration and the ADDR_BASE default from shared package rv32i_pkg.
REQ-027 SHALL place lane extract/extend and lane merge in one combinational sub-module, lsu_lane.

Verification
REQ-028 SHALL verify: lw @0x80000100, memory word 0xDEADBEEF -> o_rsp_valid 2 cycles after acceptance, rdata 0xDEADBEEF, err=0.
REQ-029 SHALL verify: lb @0x80000103 and lbu @0x80000103, word 0x80FF7F01 -> rdata 0xFFFFFF80 and 0x00000080 respectively.
REQ-030 SHALL verify: sh @0x80000042, wdata 0x0000ABCD, old word 0x11223344 -> memory holds 0xABCD3344, one memread falling edge, rsp 6 cycles after acceptance.
REQ-031 SHALL verify: sw @0x80000004 data 0x12345678, then lw @0x80000004 -> reads back 0x12345678, and the master never drives the bus while o_memread=1.
REQ-032 SHALL verify: lw @0x80000002, sh @0x80000001, lw @0x80000400 and funct3=3 -> each gives err=1 after 1 cycle with no bus cycle and no memread edge.
REQ-033 SHALL verify: i_nreset pulled low during WR_HOLD of sw @0x80000008 -> memory word unchanged, o_memread=1, bus released, no o_rsp_valid.
